// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-port instruction memory between the fetch unit (read-only) and the loader/debug port (read/write)
//   clock, reset                  : system clock, asynchronous active-high reset
//   f_req/f_addr -> f_gnt         : fetch request, held until granted
//   f_rvalid/f_rdata              : fetch read response, one cycle after grant
//   l_req/l_we/l_addr/l_wdata     : loader request, held until granted
//   l_gnt, l_rvalid/l_rdata       : loader grant and read response
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory port, read data one cycle after mem_en & !mem_we
//   IMEM_MISALIGN_ERR_EN adds f_err/l_err: misaligned requests are granted, skip the memory and answer with an error
module imem_arbiter #(
  parameter int DEPTH = 128,
  parameter int MAX_FETCH_BURST = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
`ifdef IMEM_MISALIGN_ERR_EN
  ,
  output logic          f_err,
  output logic          l_err
`endif
);
  typedef enum logic {FETCH_PRI, LOADER_TURN} state_t;
  typedef enum logic [1:0] {NONE, OWN_F, OWN_L} owner_t;
  state_t state;
  owner_t owner;
  logic [3:0] streak;
  logic [3:0] streak_inc;
  logic err_q;
  logic f_mis, l_mis;
  logic unused_bits;
  assign unused_bits = ^{f_addr[31:AW+2], f_addr[1:0], l_addr[31:AW+2], l_addr[1:0]};
`ifdef IMEM_MISALIGN_ERR_EN
  assign f_mis = f_addr[1:0] != 2'b00;
  assign l_mis = l_addr[1:0] != 2'b00;
  assign f_err = f_rvalid & err_q;
  assign l_err = l_rvalid & err_q;
`else
  assign f_mis = 1'b0;
  assign l_mis = 1'b0;
`endif
  // grants are masked during reset so every output reads 0 while it is held
  always_comb begin
    f_gnt      = !reset & f_req & (state == FETCH_PRI | !l_req);
    l_gnt      = !reset & l_req & (state == LOADER_TURN | !f_req);
    mem_en     = (f_gnt & !f_mis) | (l_gnt & !l_mis);
    mem_we     = l_gnt & !l_mis & l_we;
    mem_addr   = l_gnt ? l_addr[AW+1:2] : f_gnt ? f_addr[AW+1:2] : '0;
    mem_wdata  = l_gnt ? l_wdata : '0;
    f_rvalid   = owner == OWN_F;
    l_rvalid   = owner == OWN_L;
    f_rdata    = (f_rvalid & !err_q) ? mem_rdata : '0;
    l_rdata    = (l_rvalid & !err_q) ? mem_rdata : '0;
    streak_inc = streak + 4'd1;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= FETCH_PRI;
      streak <= '0;
      owner  <= NONE;
      err_q  <= 1'b0;
    end else begin
      // LOADER_TURN always lasts one cycle: either the loader is granted or it has withdrawn
      state  <= (state == FETCH_PRI && f_gnt && l_req && streak_inc == 4'(MAX_FETCH_BURST)) ? LOADER_TURN : FETCH_PRI;
      streak <= (!l_req || l_gnt) ? '0 : f_gnt ? streak_inc : streak;
      owner  <= f_gnt ? OWN_F : (l_gnt && (!l_we || l_mis)) ? OWN_L : NONE;
      err_q  <= f_gnt ? f_mis : (l_gnt & l_mis);
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: randomized and directed check of imem_arbiter against a behavioural model
module tb_imem_arbiter;
  localparam int DEPTH = 128;
  localparam int MAXB = 4;
  localparam int AW = $clog2(DEPTH);
  logic clock = 1'b0;
  logic reset, preload;
  logic f_req, l_req, l_we;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic f_gnt, f_rvalid, l_gnt, l_rvalid, mem_en, mem_we;
  logic [31:0] f_rdata, l_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
`ifdef IMEM_MISALIGN_ERR_EN
  logic f_err, l_err;
`endif
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int n_chk = 0, n_fail = 0;
  int streak = 0;
  logic eg, el;
  logic pend_f = 0, pend_l = 0, pend_fe = 0, pend_le = 0;
  logic [31:0] pend_fd = 0, pend_ld = 0;
  logic [9:0] pat;

  imem_arbiter #(.DEPTH(DEPTH), .MAX_FETCH_BURST(MAXB)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef IMEM_MISALIGN_ERR_EN
    , .f_err(f_err), .l_err(l_err)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(int i);
    return i == 2 ? 32'h00500093 : i == 3 ? 32'h00100113 : (i * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic misal(input logic [31:0] a);
`ifdef IMEM_MISALIGN_ERR_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // One cycle: check last cycle's responses and this cycle's grant/memory drive, then advance the model.
  task automatic step();
    logic mf, ml;
    int fi, li;
    @(negedge clock);
    chk("f_rvalid", f_rvalid, pend_f);
    chk("f_rdata", f_rdata, pend_f ? pend_fd : 32'h0);
    chk("l_rvalid", l_rvalid, pend_l);
    chk("l_rdata", l_rdata, pend_l ? pend_ld : 32'h0);
`ifdef IMEM_MISALIGN_ERR_EN
    chk("f_err", f_err, pend_f & pend_fe);
    chk("l_err", l_err, pend_l & pend_le);
`endif
    mf = misal(f_addr);
    ml = misal(l_addr);
    // the loader wins when fetch is idle or fetch has used up its burst allowance
    el = l_req && (!f_req || streak == MAXB);
    eg = f_req && !el;
    fi = int'((f_addr >> 2) % DEPTH);
    li = int'((l_addr >> 2) % DEPTH);
    chk("f_gnt", f_gnt, eg);
    chk("l_gnt", l_gnt, el);
    chk("mem_en", mem_en, (eg && !mf) || (el && !ml));
    chk("mem_we", mem_we, el && l_we && !ml);
    chk("mem_wdata", mem_wdata, el ? l_wdata : 32'h0);
    if (eg && !mf) chk("mem_addr_f", mem_addr, fi);
    if (el && !ml) chk("mem_addr_l", mem_addr, li);
    pend_f = eg;
    pend_fd = mf ? 32'h0 : ref_mem[fi];
    pend_fe = mf;
    pend_l = el && (!l_we || ml);
    pend_ld = ml ? 32'h0 : ref_mem[li];
    pend_le = ml;
    if (el && l_we && !ml) ref_mem[li] = l_wdata;
    streak = (!l_req || el) ? 0 : eg ? streak + 1 : streak;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
`ifdef IMEM_MISALIGN_ERR_EN
    return ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
`else
    return $urandom;
`endif
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    f_req = 0; l_req = 0; l_we = 0; f_addr = 0; l_addr = 0; l_wdata = 0;
    preload = 1; reset = 1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_f_rvalid", f_rvalid, 0);
    chk("rst_l_rvalid", l_rvalid, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_l_rdata", l_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(negedge clock);
    preload = 0; reset = 0;
    @(posedge clock);
    #1;
    // fetch two consecutive words
    f_req = 1; f_addr = 32'h8;
    #1; chk("t1_gnt0", f_gnt, 1); chk("t1_addr0", mem_addr, 2);
    step();
    f_addr = 32'hC;
    #1; chk("t1_gnt1", f_gnt, 1); chk("t1_addr1", mem_addr, 3);
    chk("t1_rd0", f_rdata, 32'h00500093);
    step();
    f_req = 0;
    chk("t1_rd1", f_rdata, 32'h00100113);
    step();
    // loader write then fetch it back
    l_req = 1; l_we = 1; l_addr = 32'h10; l_wdata = 32'hDEADBEEF;
    #1; chk("t2_lgnt", l_gnt, 1); chk("t2_we", mem_we, 1); chk("t2_addr", mem_addr, 4);
    step();
    l_req = 0; l_we = 0;
    chk("t2_no_rvalid", l_rvalid, 0);
    f_req = 1; f_addr = 32'h10;
    step();
    f_req = 0;
    chk("t2_rd", f_rdata, 32'hDEADBEEF);
    step();
    // contention: burst of MAXB fetches then one loader slot
    f_req = 1; f_addr = 32'h20; l_req = 1; l_we = 0; l_addr = 32'h14;
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      pat = {pat[8:0], l_gnt};
      step();
    end
    chk("t3_pattern", pat, 10'b0000100001);
    f_req = 0; l_req = 0;
    step();
    // address wrap
    l_req = 1; l_addr = 32'h204;
    #1; chk("t4_wrap", mem_addr, 1);
    step();
    l_req = 0;
    step();
    // reset during an in-flight fetch
    f_req = 1; f_addr = 32'h8;
    @(negedge clock);
    chk("t5_gnt", f_gnt, 1);
    reset = 1;
    #1;
    chk("t5_rst_fgnt", f_gnt, 0);
    chk("t5_rst_mem_en", mem_en, 0);
    chk("t5_rst_addr", mem_addr, 0);
    @(posedge clock);
    #1;
    chk("t5_rvalid_rst", f_rvalid, 0);
    chk("t5_rdata_rst", f_rdata, 0);
    @(negedge clock);
    reset = 0; f_req = 0;
    pend_f = 0; pend_l = 0; streak = 0;
    @(posedge clock);
    #1;
    chk("t5_rvalid_after", f_rvalid, 0);
    f_req = 1; l_req = 1; l_we = 0; l_addr = 32'h0;
    #1; chk("t5_fetch_pri", f_gnt, 1);
    step();
    f_req = 0; l_req = 0;
    step();
`ifdef IMEM_MISALIGN_ERR_EN
    f_req = 1; f_addr = 32'h6;
    #1; chk("t6_gnt", f_gnt, 1); chk("t6_mem_en", mem_en, 0);
    step();
    f_req = 0;
    chk("t6_rvalid", f_rvalid, 1); chk("t6_err", f_err, 1); chk("t6_rdata", f_rdata, 0);
    step();
`endif
    // randomized traffic; requests stay stable until granted
    for (int c = 0; c < 500; c++) begin
      if (!f_req || eg) begin
        f_req = $urandom_range(0, 3) != 0;
        f_addr = rand_addr();
      end
      if (!l_req || el) begin
        l_req = $urandom_range(0, 2) != 0;
        l_we = $urandom_range(0, 1) == 1;
        l_addr = rand_addr();
        l_wdata = $urandom;
      end
      step();
    end
    f_req = 0; l_req = 0;
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
